vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Transaction controller for the vending datapath.
- Accumulates inserted coins into a credit balance and validates item selections against a per-item price table and stock counters.
- Sequences the item dispenser through a req/ready handshake, then pays out change coin-by-coin through a second req/ready handshake.
- Sits between the coin acceptor and keypad on one side and the dispenser and payout hopper on the other.

Parameters:
PRICE0, 175, price of item 0 in cents (multiple of 5)
PRICE1, 150, price of item 1 in cents
PRICE2, 125, price of item 2 in cents
PRICE3, 100, price of item 3 in cents
MAX_BALANCE, 995, credit ceiling in cents; must be at most 1023
STOCK_INIT, 8, units loaded per item at reset (fits 4 bits)

Ports:
clock  input  1  system clock, all state updates on rising edge
resetN  input  1  asynchronous active-low reset
coinValid  input  1  one-cycle strobe, coin present on coinValue
coinValue  input  7  coin value in cents
selectValid  input  1  one-cycle strobe, item request on select
select  input  2  item index 0..3
coinReturn  input  1  request refund of current balance
vendReady  input  1  dispenser accepts the current vendReq
payReady  input  1  hopper accepts the current payReq
vendReq  output  1  dispense request, held until accepted
vendItem  output  2  item being dispensed, stable while vendReq=1
payReq  output  1  payout request, held until accepted
payCoin  output  2  coin to pay: 01 nickel, 10 dime, 11 quarter
balance  output  10  current credit in cents
busy  output  1  high in any state other than IDLE
coinReject  output  1  one-cycle pulse, coin refused
denied  output  1  one-cycle pulse, selection refused (insufficient credit)
soldOut  output  1  one-cycle pulse, selection refused (stock zero)

Behaviour:
- Reset (resetN=0, asynchronous):
  - State goes to IDLE.
  - balance=0, all outputs 0, payCoin=00.
  - Every stock counter is set to STOCK_INIT.
  - Reset mid-transaction discards credit and any pending handshake.
- States: IDLE, VEND, CHANGE. All outputs are registered.
- Coin handling in IDLE, when coinValid=1:
  - The coin is refused (coinReject pulse, balance unchanged) if coinValue is 0, coinValue is not a multiple of 5, or balance+coinValue > MAX_BALANCE.
  - Otherwise balance += coinValue on the next edge.
- Coins outside IDLE: any coinValid in VEND or CHANGE is refused with a coinReject pulse.
- Selection in IDLE, when selectValid=1:
  - The selection is evaluated against effCredit = balance plus any coin accepted in the same cycle.
  - If stock[select]==0: soldOut pulse, stay in IDLE. soldOut takes precedence over denied.
  - Else if effCredit < PRICE[select]: denied pulse, stay in IDLE; the coin is still credited.
  - Else go to VEND with vendReq=1, vendItem=select, and balance = effCredit - PRICE[select] written at the same edge.
- selectValid outside IDLE is ignored, with no pulse.
- coinReturn in IDLE:
  - If a valid selection is present in the same cycle, the selection wins and coinReturn is ignored.
  - Otherwise, if balance (including a same-cycle coin) >= 5, go to CHANGE.
  - If balance is 0, it is ignored.
- VEND:
  - vendReq and vendItem are held until the first cycle with vendReady=1.
  - On that edge: vendReq=0, stock[vendItem] decrements, then go to CHANGE if balance>=5, else IDLE.
  - There is no timeout.
- CHANGE (greedy payout):
  - Coin choice is quarter if balance>=25, else dime if balance>=10, else nickel.
  - payReq=1 and payCoin are held until payReady=1.
  - On the handshake edge, balance decreases by the coin value.
  - If the new balance is 0, deassert payReq, set payCoin=00, and go to IDLE. Otherwise present the next coin the following cycle.
  - payReq may stay high across back-to-back coins.
- Latency:
  - A selection is visible on vendReq one cycle after selectValid.
  - The first payout coin appears one cycle after vend completion or after coinReturn.
- Arithmetic: balance is 10-bit unsigned. The MAX_BALANCE check prevents overflow. Subtraction never underflows by construction. Stock decrements saturate at 0 (defensive).
- busy = (state != IDLE). The three refusal pulses last exactly one cycle each.

Test Plan:
1. Reset, then coins 100 and 100 on separate cycles, then select=0 (175) -> balance 200, vendReq=1 with vendItem=0; after vendReady, payout is one quarter; balance ends at 0, back in IDLE, stock[0]=7.
2. Balance 100, select=1 (150) -> denied pulse, balance stays 100, no vendReq. Then coinReturn -> payout sequence of 25, 25, 25, 25 with payReady stalled 3 cycles on the second coin; payReq and payCoin stay stable through the stall.
3. Balance 40, coinReturn with payReady always 1 -> coins 11, 10, 01 (25, 10, 5) on consecutive cycles, then IDLE with balance 0.
4. Vend item 3 eight times with exact credit -> ninth select=3 gives soldOut with balance preserved. Coin 7 or 0 -> coinReject. Balance 990 plus coin 25 -> coinReject.
5. Same cycle coinValid(25), selectValid(3), coinReturn with balance 75 -> coin credited, vend item 3, balance 0, coinReturn ignored, IDLE after vendReady. Coin inserted during VEND -> coinReject.
6. Assert resetN low while in CHANGE with payReq high -> outputs clear immediately (asynchronously), balance 0, stock back to STOCK_INIT, IDLE after release.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credits coins, validates selections against
// price and stock, then sequences the dispenser and greedy change payout.
module vend_sequencer #(
  parameter int unsigned PRICE0      = 175,
  parameter int unsigned PRICE1      = 150,
  parameter int unsigned PRICE2      = 125,
  parameter int unsigned PRICE3      = 100,
  parameter int unsigned MAX_BALANCE = 995,
  parameter int unsigned STOCK_INIT  = 8
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       coinValid,
  input  logic [6:0] coinValue,
  input  logic       selectValid,
  input  logic [1:0] select,
  input  logic       coinReturn,
  input  logic       vendReady,
  input  logic       payReady,
  output logic       vendReq,
  output logic [1:0] vendItem,
  output logic       payReq,
  output logic [1:0] payCoin,
  output logic [9:0] balance,
  output logic       busy,
  output logic       coinReject,
  output logic       denied,
  output logic       soldOut
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  stock_r [4];

  logic [10:0] coin_sum_s;
  logic        coin_ok_s;
  logic [9:0]  eff_credit_s;
  logic [9:0]  price_s;
  logic [3:0]  sel_stock_s;
  logic [3:0]  vend_stock_s;
  logic [9:0]  change_left_s;

  // Largest coin that still fits in the remaining amount.
  function automatic logic [1:0] pick_coin(input logic [9:0] amt);
    if (amt >= 10'd25) begin
      return 2'b11;
    end else if (amt >= 10'd10) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

  function automatic logic [9:0] coin_cents(input logic [1:0] code);
    case (code)
      2'b11:   return 10'd25;
      2'b10:   return 10'd10;
      2'b01:   return 10'd5;
      default: return 10'd0;
    endcase
  endfunction

  // Price lookup for the requested item.
  always_comb begin
    price_s = 10'd0;
    case (select)
      2'd0:    price_s = 10'(PRICE0);
      2'd1:    price_s = 10'(PRICE1);
      2'd2:    price_s = 10'(PRICE2);
      2'd3:    price_s = 10'(PRICE3);
      default: price_s = 10'd0;
    endcase
  end

  // Coin acceptance and the credit a same-cycle selection is judged against.
  always_comb begin
    coin_sum_s    = {1'b0, balance} + {4'd0, coinValue};
    coin_ok_s     = coinValid && (coinValue != 7'd0) && ((coinValue % 7'd5) == 7'd0)
                    && (coin_sum_s <= 11'(MAX_BALANCE));
    if (coin_ok_s) begin
      eff_credit_s = coin_sum_s[9:0];
    end else begin
      eff_credit_s = balance;
    end
    sel_stock_s   = stock_r[select];
    vend_stock_s  = stock_r[vendItem];
    change_left_s = balance - coin_cents(payCoin);
  end

  // Transaction FSM with registered outputs and per-item stock counters.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r    <= ST_IDLE;
      vendReq    <= 1'b0;
      vendItem   <= 2'd0;
      payReq     <= 1'b0;
      payCoin    <= 2'b00;
      balance    <= 10'd0;
      busy       <= 1'b0;
      coinReject <= 1'b0;
      denied     <= 1'b0;
      soldOut    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stock_r[i] <= 4'(STOCK_INIT);
      end
    end else begin
      coinReject <= 1'b0;
      denied     <= 1'b0;
      soldOut    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          coinReject <= coinValid && !coin_ok_s;
          if (selectValid) begin
            if (sel_stock_s == 4'd0) begin
              soldOut <= 1'b1;
              balance <= eff_credit_s;
            end else if (eff_credit_s < price_s) begin
              denied  <= 1'b1;
              balance <= eff_credit_s;
            end else begin
              state_r  <= ST_VEND;
              busy     <= 1'b1;
              vendReq  <= 1'b1;
              vendItem <= select;
              balance  <= eff_credit_s - price_s;
            end
          end else if (coinReturn && (eff_credit_s >= 10'd5)) begin
            state_r <= ST_CHANGE;
            busy    <= 1'b1;
            payReq  <= 1'b1;
            payCoin <= pick_coin(eff_credit_s);
            balance <= eff_credit_s;
          end else begin
            balance <= eff_credit_s;
          end
        end
        ST_VEND: begin
          coinReject <= coinValid;
          if (vendReady) begin
            vendReq  <= 1'b0;
            vendItem <= 2'd0;
            if (vend_stock_s != 4'd0) begin
              stock_r[vendItem] <= vend_stock_s - 4'd1;
            end
            if (balance >= 10'd5) begin
              state_r <= ST_CHANGE;
              payReq  <= 1'b1;
              payCoin <= pick_coin(balance);
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        ST_CHANGE: begin
          coinReject <= coinValid;
          if (payReady) begin
            balance <= change_left_s;
            if (change_left_s == 10'd0) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
              payReq  <= 1'b0;
              payCoin <= 2'b00;
            end else begin
              payCoin <= pick_coin(change_left_s);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          vendReq <= 1'b0;
          payReq  <= 1'b0;
          payCoin <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Table-driven scoreboard bench for vend_sequencer: per-cycle vectors carry
// inputs plus the expected registered outputs after the following edge.
module tb_vend_sequencer;

  logic       clock = 1'b0;
  logic       resetN;
  logic       coinValid;
  logic [6:0] coinValue;
  logic       selectValid;
  logic [1:0] select;
  logic       coinReturn;
  logic       vendReady;
  logic       payReady;
  logic       vendReq;
  logic [1:0] vendItem;
  logic       payReq;
  logic [1:0] payCoin;
  logic [9:0] balance;
  logic       busy;
  logic       coinReject;
  logic       denied;
  logic       soldOut;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        cv;
    logic [6:0]  cval;
    logic        sv;
    logic [1:0]  sel;
    logic        cr;
    logic        vr;
    logic        pr;
    logic [19:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] sb_q[$];

  vend_sequencer dut (
    .clock(clock), .resetN(resetN),
    .coinValid(coinValid), .coinValue(coinValue),
    .selectValid(selectValid), .select(select),
    .coinReturn(coinReturn), .vendReady(vendReady), .payReady(payReady),
    .vendReq(vendReq), .vendItem(vendItem), .payReq(payReq), .payCoin(payCoin),
    .balance(balance), .busy(busy), .coinReject(coinReject),
    .denied(denied), .soldOut(soldOut)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] ex(input logic vr, input logic [1:0] vi, input logic pr,
                                     input logic [1:0] pc, input logic [9:0] bal, input logic bz,
                                     input logic rj, input logic dn, input logic so);
    return {vr, vi, pr, pc, bal, bz, rj, dn, so};
  endfunction

  function automatic logic [19:0] idle_e(input logic [9:0] bal, input logic rj,
                                         input logic dn, input logic so);
    return ex(1'b0, 2'd0, 1'b0, 2'b00, bal, 1'b0, rj, dn, so);
  endfunction

  function automatic logic [19:0] vend_e(input logic [1:0] item, input logic [9:0] bal, input logic rj);
    return ex(1'b1, item, 1'b0, 2'b00, bal, 1'b1, rj, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] pay_e(input logic [1:0] coin, input logic [9:0] bal, input logic rj);
    return ex(1'b0, 2'd0, 1'b1, coin, bal, 1'b1, rj, 1'b0, 1'b0);
  endfunction

  function automatic vec_t mk(input string nm, input logic cv, input logic [6:0] cval,
                              input logic sv, input logic [1:0] sel, input logic cr,
                              input logic vr, input logic pr, input logic [19:0] e);
    vec_t v;
    v.name = nm; v.cv = cv; v.cval = cval; v.sv = sv; v.sel = sel;
    v.cr = cr; v.vr = vr; v.pr = pr; v.exp = e;
    return v;
  endfunction

  function automatic void add(input string nm, input logic cv, input logic [6:0] cval,
                              input logic sv, input logic [1:0] sel, input logic cr,
                              input logic vr, input logic pr, input logic [19:0] e);
    tbl.push_back(mk(nm, cv, cval, sv, sel, cr, vr, pr, e));
  endfunction

  task automatic check_now(input string nm);
    logic [19:0] e;
    logic [19:0] a;
    e = sb_q.pop_front();
    a = {vendReq, vendItem, payReq, payCoin, balance, busy, coinReject, denied, soldOut};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got vreq=%b item=%0d preq=%b coin=%b bal=%0d busy=%b rej=%b den=%b sold=%b, want vreq=%b item=%0d preq=%b coin=%b bal=%0d busy=%b rej=%b den=%b sold=%b",
               nm, a[19], a[18:17], a[16], a[15:14], a[13:4], a[3], a[2], a[1], a[0],
               e[19], e[18:17], e[16], e[15:14], e[13:4], e[3], e[2], e[1], e[0]);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clock);
    coinValid   = v.cv;
    coinValue   = v.cval;
    selectValid = v.sv;
    select      = v.sel;
    coinReturn  = v.cr;
    vendReady   = v.vr;
    payReady    = v.pr;
    sb_q.push_back(v.exp);
    @(posedge clock);
    #1;
    check_now(v.name);
  endtask

  task automatic step(input string nm, input logic cv, input logic [6:0] cval,
                      input logic sv, input logic [1:0] sel, input logic cr,
                      input logic vr, input logic pr, input logic [19:0] e);
    drive(mk(nm, cv, cval, sv, sel, cr, vr, pr, e));
  endtask

  task automatic clear_inputs();
    coinValid = 1'b0; coinValue = 7'd0; selectValid = 1'b0; select = 2'd0;
    coinReturn = 1'b0; vendReady = 1'b0; payReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    resetN = 1'b0;
    #3;
    sb_q.push_back(idle_e(10'd0, 1'b0, 1'b0, 1'b0));
    check_now("reset state");
    @(negedge clock);
    resetN = 1'b1;

    // Purchase with one quarter of change.
    add("t1 coin100a", 1'b1, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd100, 1'b0, 1'b0, 1'b0));
    add("t1 coin100b", 1'b1, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd200, 1'b0, 1'b0, 1'b0));
    add("t1 sel0",     1'b0, 7'd0,   1'b1, 2'd0, 1'b0, 1'b0, 1'b0, vend_e(2'd0, 10'd25, 1'b0));
    add("t1 vend hold",1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, vend_e(2'd0, 10'd25, 1'b0));
    add("t1 vend ack", 1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b1, 1'b0, pay_e(2'b11, 10'd25, 1'b0));
    add("t1 pay q",    1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, idle_e(10'd0, 1'b0, 1'b0, 1'b0));
    // Denied selection, then refund with a stalled hopper.
    add("t2 coin100",  1'b1, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd100, 1'b0, 1'b0, 1'b0));
    add("t2 denied",   1'b0, 7'd0,   1'b1, 2'd1, 1'b0, 1'b0, 1'b0, idle_e(10'd100, 1'b0, 1'b1, 1'b0));
    add("t2 pulse end",1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd100, 1'b0, 1'b0, 1'b0));
    add("t2 return",   1'b0, 7'd0,   1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pay_e(2'b11, 10'd100, 1'b0));
    add("t2 pay1",     1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pay_e(2'b11, 10'd75, 1'b0));
    add("t2 stall1",   1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pay_e(2'b11, 10'd75, 1'b0));
    add("t2 stall2",   1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pay_e(2'b11, 10'd75, 1'b0));
    add("t2 stall3",   1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pay_e(2'b11, 10'd75, 1'b0));
    add("t2 pay2",     1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pay_e(2'b11, 10'd50, 1'b0));
    add("t2 pay3",     1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pay_e(2'b11, 10'd25, 1'b0));
    add("t2 pay4",     1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, idle_e(10'd0, 1'b0, 1'b0, 1'b0));
    // Mixed greedy payout of 40.
    add("t3 coin25",   1'b1, 7'd25,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd25, 1'b0, 1'b0, 1'b0));
    add("t3 coin10",   1'b1, 7'd10,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd35, 1'b0, 1'b0, 1'b0));
    add("t3 coin5",    1'b1, 7'd5,   1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd40, 1'b0, 1'b0, 1'b0));
    add("t3 return",   1'b0, 7'd0,   1'b0, 2'd0, 1'b1, 1'b0, 1'b1, pay_e(2'b11, 10'd40, 1'b0));
    add("t3 pay q",    1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pay_e(2'b10, 10'd15, 1'b0));
    add("t3 pay d",    1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pay_e(2'b01, 10'd5, 1'b0));
    add("t3 pay n",    1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, idle_e(10'd0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
    end

    // Exhaust item 3, then coin refusals and the credit ceiling.
    for (int k = 0; k < 8; k++) begin
      step("t4 coin100", 1'b1, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd100, 1'b0, 1'b0, 1'b0));
      step("t4 sel3",    1'b0, 7'd0,   1'b1, 2'd3, 1'b0, 1'b0, 1'b0, vend_e(2'd3, 10'd0, 1'b0));
      step("t4 vend ack",1'b0, 7'd0,   1'b0, 2'd0, 1'b0, 1'b1, 1'b0, idle_e(10'd0, 1'b0, 1'b0, 1'b0));
    end
    step("t4 coin50",    1'b1, 7'd50, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd50, 1'b0, 1'b0, 1'b0));
    step("t4 soldout",   1'b0, 7'd0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b0, idle_e(10'd50, 1'b0, 1'b0, 1'b1));
    step("t4 coin7",     1'b1, 7'd7,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd50, 1'b1, 1'b0, 1'b0));
    step("t4 coin0",     1'b1, 7'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd50, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 9; k++) begin
      step("t4 fill100", 1'b1, 7'd100, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0,
           idle_e(10'(50 + 100 * (k + 1)), 1'b0, 1'b0, 1'b0));
    end
    step("t4 coin25",    1'b1, 7'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd975, 1'b0, 1'b0, 1'b0));
    step("t4 coin15",    1'b1, 7'd15, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd990, 1'b0, 1'b0, 1'b0));
    step("t4 over 1015", 1'b1, 7'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd990, 1'b1, 1'b0, 1'b0));
    step("t4 exact 995", 1'b1, 7'd5,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd995, 1'b0, 1'b0, 1'b0));
    step("t4 over 1000", 1'b1, 7'd5,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd995, 1'b1, 1'b0, 1'b0));
    step("t6 return",    1'b0, 7'd0,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pay_e(2'b11, 10'd995, 1'b0));
    step("t6 pay1",      1'b0, 7'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, pay_e(2'b11, 10'd970, 1'b0));
    step("t6 coin in chg",1'b1, 7'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, pay_e(2'b11, 10'd970, 1'b1));
    step("t6 sel ignored",1'b0, 7'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, pay_e(2'b11, 10'd970, 1'b0));

    // Asynchronous reset while payReq is high, checked between clock edges.
    clear_inputs();
    #2;
    resetN = 1'b0;
    #1;
    sb_q.push_back(idle_e(10'd0, 1'b0, 1'b0, 1'b0));
    check_now("t6 async reset");
    @(negedge clock);
    resetN = 1'b1;
    step("t6 after release", 1'b0, 7'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd0, 1'b0, 1'b0, 1'b0));

    // Same-cycle coin + select + return; item 3 is restocked by the reset.
    step("t5 coin50",    1'b1, 7'd50, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd50, 1'b0, 1'b0, 1'b0));
    step("t5 coin25",    1'b1, 7'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd75, 1'b0, 1'b0, 1'b0));
    step("t5 combined",  1'b1, 7'd25, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, vend_e(2'd3, 10'd0, 1'b0));
    step("t5 coin in vend",1'b1, 7'd25, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, vend_e(2'd3, 10'd0, 1'b1));
    step("t5 vend ack",  1'b0, 7'd0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b0, idle_e(10'd0, 1'b0, 1'b0, 1'b0));
    step("t5 coin+deny", 1'b1, 7'd25, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, idle_e(10'd25, 1'b0, 1'b1, 1'b0));
    step("t5 return",    1'b0, 7'd0,  1'b0, 2'd0, 1'b1, 1'b0, 1'b0, pay_e(2'b11, 10'd25, 1'b0));
    step("t5 pay q",     1'b0, 7'd0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b1, idle_e(10'd0, 1'b0, 1'b0, 1'b0));
    step("t5 return at 0",1'b0, 7'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, idle_e(10'd0, 1'b0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
